// File: rtl/rx_block_assembler.sv
// rx_block_assembler
// Collects NUM_WORDS received words into one wide block. The consumer takes
// the block through a valid/ready handshake. Optionally, a partial block that
// goes idle for too long is discarded.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   d_in         received word, sampled when rx_done=1
//   rx_done      one-cycle word strobe (level-sensitive: k cycles high = k words)
//   flush        synchronous discard of the partial or held block
//   out_ready    consumer accepts the block
//   d_out        assembled block
//   shift_done   block valid
//   word_cnt     words captured in the current block
//   overflow     one-cycle pulse: a word was dropped while holding a block
//   timeout_err  one-cycle pulse: a partial block was discarded on timeout
//
// state | meaning
// IDLE  | no words captured, word_cnt = 0
// FILL  | partial block, 0 < word_cnt < NUM_WORDS, idle counter running
// HOLD  | full block presented, shift_done = 1, waiting for out_ready
module rx_block_assembler #(
  parameter  int DATA_W      = 8,
  parameter  int NUM_WORDS   = 16,
  parameter  int MSB_FIRST   = 1,
  parameter  int TIMEOUT_CYC = 0,
  localparam int OUT_W       = DATA_W * NUM_WORDS,
  localparam int CNT_W       = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rx_done,
  input  logic              flush,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  d_out,
  output logic              shift_done,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // The idle counter holds the idle cycles already elapsed. The timeout fires
  // in the cycle that completes the TIMEOUT_CYC-th cycle since the last capture.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t             state, state_nx;
  logic [OUT_W-1:0]   d_out_nx, d_shift;
  logic [CNT_W-1:0]   cnt_nx;
  logic [IDLE_W-1:0]  idle_cnt, idle_nx;
  logic               overflow_nx, timeout_nx, capture, idle_hit;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign d_shift = {d_out[OUT_W-DATA_W-1:0], d_in};
    end else begin : g_lsb
      assign d_shift = {d_in, d_out[OUT_W-1:DATA_W]};
    end
  endgenerate

  assign idle_hit   = (TIMEOUT_CYC != 0) && (idle_cnt == IDLE_LAST);
  assign shift_done = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      d_out       <= '0;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      d_out       <= d_out_nx;
      word_cnt    <= cnt_nx;
      idle_cnt    <= idle_nx;
      overflow    <= overflow_nx;
      timeout_err <= timeout_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    d_out_nx    = d_out;
    cnt_nx      = word_cnt;
    idle_nx     = idle_cnt;
    overflow_nx = 1'b0;
    timeout_nx  = 1'b0;
    capture     = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idle_nx  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_done) begin
            capture  = 1'b1;
            cnt_nx   = CNT_W'(1);
            idle_nx  = '0;
            state_nx = FILL;
          end
        end
        FILL: begin
          if (idle_hit) begin
            // Partial block is dropped; a coincident word starts a new block.
            timeout_nx = 1'b1;
            idle_nx    = '0;
            if (rx_done) begin
              capture  = 1'b1;
              cnt_nx   = CNT_W'(1);
            end else begin
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end else if (rx_done) begin
            capture = 1'b1;
            cnt_nx  = word_cnt + CNT_W'(1);
            idle_nx = '0;
            if (word_cnt == LAST_CNT) state_nx = HOLD;
          end else if (idle_cnt != IDLE_MAX) begin
            idle_nx = idle_cnt + IDLE_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            idle_nx = '0;
            if (rx_done) begin
              capture  = 1'b1;
              cnt_nx   = CNT_W'(1);
              state_nx = FILL;
            end else begin
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end else if (rx_done) begin
            overflow_nx = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idle_nx  = '0;
        end
      endcase
    end
    if (capture) d_out_nx = d_shift;
  end

endmodule

// File: tb/tb_rx_block_assembler.sv
module tb_rx_block_assembler;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   d_in;
  logic         rx_done, flush, out_ready;

  // instance a: MSB_FIRST=1, TIMEOUT_CYC=100 ; instance b: MSB_FIRST=0, no timeout
  logic [127:0] d_out_a, d_out_b;
  logic         shift_done_a, shift_done_b;
  logic [4:0]   word_cnt_a, word_cnt_b;
  logic         overflow_a, overflow_b, timeout_err_a, timeout_err_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rx_block_assembler #(.DATA_W(8), .NUM_WORDS(16), .MSB_FIRST(1), .TIMEOUT_CYC(100)) dut_a (
    .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_done), .flush(flush),
    .out_ready(out_ready), .d_out(d_out_a), .shift_done(shift_done_a),
    .word_cnt(word_cnt_a), .overflow(overflow_a), .timeout_err(timeout_err_a));

  rx_block_assembler #(.DATA_W(8), .NUM_WORDS(16), .MSB_FIRST(0), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_done), .flush(flush),
    .out_ready(out_ready), .d_out(d_out_b), .shift_done(shift_done_b),
    .word_cnt(word_cnt_b), .overflow(overflow_b), .timeout_err(timeout_err_b));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a list of words per block, a "full" flag, and the
  // number of cycles since the last captured word.
  int         m_cnt  [2] = '{0, 0};
  bit         m_full [2] = '{0, 0};
  int         m_since[2] = '{0, 0};
  bit         m_ovf  [2] = '{0, 0};
  bit         m_tmo  [2] = '{0, 0};
  logic [7:0] m_words[2][16];
  int         m_tcyc [2] = '{100, 0};

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_cnt[k] = 0; m_full[k] = 0; m_since[k] = 0; m_ovf[k] = 0; m_tmo[k] = 0;
      end else begin
        m_ovf[k] = 0;
        m_tmo[k] = 0;
        if (flush) begin
          m_cnt[k] = 0; m_full[k] = 0; m_since[k] = 0;
        end else if (m_full[k]) begin
          if (out_ready) begin
            m_full[k] = 0;
            m_since[k] = 0;
            if (rx_done) begin m_words[k][0] = d_in; m_cnt[k] = 1; end
            else m_cnt[k] = 0;
          end else if (rx_done) begin
            m_ovf[k] = 1;
          end
        end else if (m_cnt[k] > 0 && m_tcyc[k] > 0 && m_since[k] + 1 == m_tcyc[k]) begin
          m_tmo[k] = 1;
          m_since[k] = 0;
          if (rx_done) begin m_words[k][0] = d_in; m_cnt[k] = 1; end
          else m_cnt[k] = 0;
        end else if (rx_done) begin
          m_words[k][m_cnt[k]] = d_in;
          m_cnt[k]++;
          m_since[k] = 0;
          if (m_cnt[k] == 16) m_full[k] = 1;
        end else if (m_cnt[k] > 0 && m_since[k] < 1000) begin
          m_since[k]++;
        end
      end
    end
  end

  function automatic logic [127:0] exp_block(input int k);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      if (k == 0) r[(15-i)*8 +: 8] = m_words[k][i];
      else        r[i*8 +: 8]      = m_words[k][i];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    chk("a.shift_done",  shift_done_a,  m_full[0]);
    chk("a.word_cnt",    word_cnt_a,    m_cnt[0]);
    chk("a.overflow",    overflow_a,    m_ovf[0]);
    chk("a.timeout_err", timeout_err_a, m_tmo[0]);
    chk("b.shift_done",  shift_done_b,  m_full[1]);
    chk("b.word_cnt",    word_cnt_b,    m_cnt[1]);
    chk("b.overflow",    overflow_b,    m_ovf[1]);
    chk("b.timeout_err", timeout_err_b, m_tmo[1]);
    if (m_full[0]) chk("a.d_out", d_out_a, exp_block(0));
    if (m_full[1]) chk("b.d_out", d_out_b, exp_block(1));
  end

  task automatic step(input logic rx, input logic [7:0] d, input logic fl, input logic rdy);
    rx_done = rx; d_in = d; flush = fl; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, base + 8'(i), 1'b0, 1'b0);
      if (i != n - 1) repeat (gap) step(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; d_in = 8'h00; rx_done = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset d_out_a", d_out_a, 128'h0);
    chk("reset word_cnt_a", word_cnt_a, 5'd0);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // bytes 0x00..0x0F with 8 idle cycles between strobes
    send(8'h00, 16, 8);
    chk("blk0 shift_done", shift_done_a, 1'b1);
    chk("blk0 word_cnt", word_cnt_a, 5'd16);
    chk("blk0 d_out msb", d_out_a, 128'h000102030405060708090A0B0C0D0E0F);
    chk("blk0 d_out lsb", d_out_b, 128'h0F0E0D0C0B0A09080706050403020100);

    // overflow in HOLD, then handshake with a coincident word
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf pulse", overflow_a, 1'b1);
    chk("ovf d_out held", d_out_a, 128'h000102030405060708090A0B0C0D0E0F);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("hs shift_done", shift_done_a, 1'b0);
    chk("hs word_cnt", word_cnt_a, 5'd1);
    chk("hs d_out[7:0]", d_out_a[7:0], 8'h55);
    chk("hs d_out_b top", d_out_b[127:120], 8'h55);
    chk("hs ovf once", overflow_a, 1'b0);

    // flush at word_cnt=7 (beats a coincident strobe), then flush in HOLD
    send(8'h60, 6, 0);
    chk("pre-flush cnt", word_cnt_a, 5'd7);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("flush fill cnt", word_cnt_a, 5'd0);
    send(8'h30, 16, 0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    chk("flush hold cnt", word_cnt_a, 5'd0);
    chk("flush hold shift", shift_done_a, 1'b0);
    chk("flush hold ovf", overflow_a, 1'b0);

    // timeout: 5 bytes then 100 idle cycles
    send(8'h40, 5, 0);
    repeat (99) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre-timeout tmo", timeout_err_a, 1'b0);
    chk("pre-timeout cnt", word_cnt_a, 5'd5);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("timeout pulse", timeout_err_a, 1'b1);
    chk("timeout cnt", word_cnt_a, 5'd0);
    chk("no-timeout b cnt", word_cnt_b, 5'd5);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("timeout once", timeout_err_a, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h10, 16, 0);
    chk("post-timeout d_out", d_out_a, 128'h101112131415161718191A1B1C1D1E1F);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // word arriving in the very cycle the timeout fires
    send(8'h50, 5, 0);
    repeat (99) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("tmo+rx pulse", timeout_err_a, 1'b1);
    chk("tmo+rx cnt", word_cnt_a, 5'd1);
    chk("tmo+rx d_out[7:0]", d_out_a[7:0], 8'hEE);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset at word_cnt=9
    send(8'h80, 9, 0);
    chk("pre-reset cnt", word_cnt_a, 5'd9);
    #2 reset = 1'b0;
    #1;
    chk("async rst d_out", d_out_a, 128'h0);
    chk("async rst cnt", word_cnt_a, 5'd0);
    chk("async rst cnt b", word_cnt_b, 5'd0);
    chk("async rst flags", {shift_done_a, overflow_a, timeout_err_a}, 3'b000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post-release cnt", word_cnt_a, 5'd0);
    send(8'h20, 16, 0);
    chk("post-reset d_out a", d_out_a, 128'h202122232425262728292A2B2C2D2E2F);
    chk("post-reset d_out b", d_out_b, 128'h2F2E2D2C2B2A29282726252423222120);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_block_assembler.md
RX_BLOCK_ASSEMBLER -- requirements
Module: rx_block_assembler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 8: width of one received word.
REQ-003 Parameter NUM_WORDS, default 16: words per assembled block (≥2).
REQ-004 Parameter MSB_FIRST, default 1: 1 = first word lands in the top slice of d_out; 0 = first word lands in the bottom slice.
REQ-005 Parameter TIMEOUT_CYC, default 0: inter-word idle limit in cycles; 0 disables the timeout.
REQ-006 Derived parameters: OUT_W = DATA_W*NUM_WORDS; CNT_W = $clog2(NUM_WORDS+1).
REQ-007 Ports SHALL be as follows:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  d_in  in  DATA_W  received word, sampled when rx_done=1
  rx_done  in  1  one-cycle word strobe from the receiver
  flush  in  1  synchronous discard of the partial or held block
  out_ready  in  1  consumer accepts the block
  d_out  out  OUT_W  assembled block
  shift_done  out  1  block valid (valid/ready handshake with out_ready)
  word_cnt  out  CNT_W  words captured in the current block
  overflow  out  1  one-cycle pulse: a word was dropped
  timeout_err  out  1  one-cycle pulse: a partial block was discarded on timeout

Function
REQ-008 The FSM SHALL have states IDLE (word_cnt=0), FILL (0<word_cnt<NUM_WORDS) and HOLD (shift_done=1).
REQ-009 In IDLE or FILL, on rx_done=1 the block SHALL capture d_in on that edge and increment word_cnt.
REQ-010 With MSB_FIRST=1, a capture SHALL perform d_out <= {d_out[OUT_W-DATA_W-1:0], d_in}; with MSB_FIRST=0, it SHALL perform d_out <= {d_in, d_out[OUT_W-1:DATA_W]}.
REQ-011 On the edge that captures word NUM_WORDS, the block SHALL set shift_done=1 and enter HOLD; the latency from the last strobe to shift_done is one clock edge.
REQ-012 In HOLD, d_out and word_cnt (=NUM_WORDS) SHALL remain stable until shift_done && out_ready.
REQ-013 On shift_done && out_ready, the block SHALL clear shift_done on the next edge and set word_cnt=0, returning to IDLE.
REQ-014 If rx_done=1 in the same cycle as the handshake, the word SHALL be accepted as word 1 of the next block: word_cnt=1, state FILL, no overflow.
REQ-015 If rx_done=1 in HOLD without out_ready, the word SHALL be dropped, d_out SHALL stay unchanged, and overflow SHALL pulse for one cycle.
REQ-016 The idle counter SHALL reset on every captured word and SHALL count only in FILL.
REQ-017 If TIMEOUT_CYC>0 and the idle counter reaches TIMEOUT_CYC, the block SHALL set word_cnt=0, return to IDLE and pulse timeout_err for one cycle; d_out contents are don't-care.
REQ-018 If rx_done=1 in the cycle the timeout fires, the word SHALL be captured as word 1 of a new block and timeout_err SHALL still pulse.
REQ-019 flush=1 SHALL have priority over rx_done, out_ready and the timeout: the block SHALL set word_cnt=0, clear shift_done, go to IDLE, and raise no overflow or timeout_err.
REQ-020 The idle counter SHALL be wide enough for TIMEOUT_CYC and SHALL saturate, never wrap.
REQ-021 rx_done held high for k cycles SHALL count as k words, because the block does no edge detection.

Reset
REQ-022 While reset=0, the block SHALL asynchronously force d_out=0, shift_done=0, word_cnt=0, overflow=0, timeout_err=0, idle counter=0 and state IDLE.
REQ-023 A reset asserted mid-FILL or in HOLD SHALL discard the block with no output pulses.
REQ-024 The block SHALL capture no word on the first edge after reset release unless rx_done=1 on that edge.

Verification
REQ-025 Defaults, bytes 0x00..0x0F, each as a 1-cycle strobe with 8 idle cycles between -> shift_done=1 one edge after the 16th strobe; d_out=128'h000102030405060708090A0B0C0D0E0F; word_cnt=16.
REQ-026 MSB_FIRST=0, same bytes -> d_out=128'h0F0E0D0C0B0A09080706050403020100.
REQ-027 Full block, out_ready=0, byte 0xAA strobed -> overflow pulses once; d_out unchanged; then out_ready=1 together with a 0x55 strobe -> shift_done=0, word_cnt=1, d_out[7:0]=8'h55.
REQ-028 TIMEOUT_CYC=100, 5 bytes then 100 idle cycles -> timeout_err pulses exactly once; word_cnt=0; 16 further bytes then assemble correctly.
REQ-029 flush asserted at word_cnt=7, and separately in HOLD -> word_cnt=0, shift_done=0, no overflow or timeout_err.
REQ-030 reset=0 asynchronously (between clock edges) at word_cnt=9 -> all outputs 0 immediately; after release, 16 bytes assemble to the expected value.
